alu_pipe: RTL

- Parametrised, registered successor to the single-cycle combinational ALU of the XM23 execute stage.
- Adds operand width generalisation, byte/word mode and full PSW flag generation (C, Z, N, V).
- Adds valid/ready handshakes on both sides and a multi-cycle, digit-serial DADD engine.
- Sits between decode/operand-fetch and writeback/PSW update.

---
 rtl/alu_pkg.sv | 38 +++
 rtl/bcd_digit_add.sv | 35 +++
 rtl/alu_pipe.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// +----------------------------------------------------------------------+
// | alu_pkg : shared types and constants for the pipelined XM23 ALU      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package alu_pkg;

    localparam int BYTE_W   = 8;
    localparam int NIBBLE_W = 4;

    typedef enum logic [3:0] {
        ALU_AND  = 4'd0,
        ALU_OR   = 4'd1,
        ALU_XOR  = 4'd2,
        ALU_BIT  = 4'd3,
        ALU_BIC  = 4'd4,
        ALU_BIS  = 4'd5,
        ALU_ADD  = 4'd6,
        ALU_SUB  = 4'd7,
        ALU_DADD = 4'd8
    } alu_mode_e;

    typedef struct packed {
        logic v;
        logic n;
        logic z;
        logic c;
    } alu_flags_t;

    typedef enum logic [0:0] {
        ST_IDLE      = 1'b0,
        ST_DADD_BUSY = 1'b1
    } alu_state_e;

endpackage

`default_nettype wire

// File: rtl/bcd_digit_add.sv
// +----------------------------------------------------------------------+
// | bcd_digit_add : one BCD digit adder with decimal carry correction    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module bcd_digit_add
    import alu_pkg::*;
(
    input  logic [NIBBLE_W-1:0] i_a,
    input  logic [NIBBLE_W-1:0] i_b,
    input  logic                i_cin,
    output logic [NIBBLE_W-1:0] o_sum,
    output logic                o_cout
);

    logic [NIBBLE_W:0] w_bin;
    logic [NIBBLE_W:0] w_adj;

    assign w_bin = {1'b0, i_a} + {1'b0, i_b} + {{NIBBLE_W{1'b0}}, i_cin};
    assign w_adj = w_bin + (NIBBLE_W+1)'(6);

    // Non-BCD digits take the same correction path; no error is raised.
    always_comb begin
        o_sum  = w_bin[NIBBLE_W-1:0];
        o_cout = 1'b0;
        if (w_bin > (NIBBLE_W+1)'(9)) begin
            o_sum  = w_adj[NIBBLE_W-1:0];
            o_cout = 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/alu_pipe.sv
// +----------------------------------------------------------------------+
// | alu_pipe : registered XM23 ALU with handshakes and digit-serial DADD |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module alu_pipe #(
    parameter int WIDTH       = 16,
    parameter int DADD_DIGITS = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       mode_select,
    input  logic             bw,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic             out_err
);

    import alu_pkg::*;

    localparam int NDIG  = WIDTH / NIBBLE_W;
    localparam int CNT_W = $clog2(NDIG) + 1;
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(NDIG / DADD_DIGITS - 1);
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'((BYTE_W / NIBBLE_W) / DADD_DIGITS - 1);

    alu_state_e       r_state, w_state_next;
    logic             r_out_valid, r_err;
    logic [WIDTH-1:0] r_result;
    alu_flags_t       r_flags;

    logic [WIDTH-1:0] r_da, r_db, r_acc;
    logic             r_dc, r_dbw;
    logic [CNT_W-1:0] r_cnt;

    alu_mode_e        w_mode;
    logic             w_in_fire, w_out_fire, w_dadd_last;
    logic [WIDTH-1:0] w_addend, w_raw, w_res;
    logic [WIDTH:0]   w_sum_w;
    logic [BYTE_W:0]  w_sum_b;
    logic             w_arith, w_err, w_msb_a, w_msb_add, w_msb_r;
    alu_flags_t       w_flags, w_dflags;

    int                              w_base;
    logic [DADD_DIGITS:0]            w_dc;
    logic [DADD_DIGITS*NIBBLE_W-1:0] w_dsum;
    logic [WIDTH-1:0]                w_acc_next;

    assign w_mode     = alu_mode_e'(mode_select);
    assign in_ready   = (r_state == ST_IDLE) && (!r_out_valid || out_ready);
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = r_out_valid && out_ready;

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign flags     = r_flags;
    assign out_err   = r_err;

    // Single-cycle datapath
    always_comb begin
        w_addend  = (w_mode == ALU_SUB) ? ~b : b;
        w_sum_w   = {1'b0, a} + {1'b0, w_addend} + {{WIDTH{1'b0}}, carry_in};
        w_sum_b   = {1'b0, a[BYTE_W-1:0]} + {1'b0, w_addend[BYTE_W-1:0]}
                  + {{BYTE_W{1'b0}}, carry_in};
        w_arith   = 1'b0;
        w_err     = 1'b0;
        w_raw     = '0;
        case (w_mode)
            ALU_AND, ALU_BIT: w_raw = a & b;
            ALU_OR,  ALU_BIS: w_raw = a | b;
            ALU_XOR:          w_raw = a ^ b;
            ALU_BIC:          w_raw = a & ~b;
            ALU_ADD, ALU_SUB: begin
                w_arith = 1'b1;
                w_raw   = bw ? {{(WIDTH-BYTE_W){1'b0}}, w_sum_b[BYTE_W-1:0]}
                             : w_sum_w[WIDTH-1:0];
            end
            ALU_DADD:         w_raw = '0;
            default:          w_err = 1'b1;
        endcase

        w_res     = bw ? {a[WIDTH-1:BYTE_W], w_raw[BYTE_W-1:0]} : w_raw;
        w_msb_a   = bw ? a[BYTE_W-1]        : a[WIDTH-1];
        w_msb_add = bw ? w_addend[BYTE_W-1] : w_addend[WIDTH-1];
        w_msb_r   = bw ? w_raw[BYTE_W-1]    : w_raw[WIDTH-1];

        w_flags.c = w_arith && (bw ? w_sum_b[BYTE_W] : w_sum_w[WIDTH]);
        w_flags.v = w_arith && (w_msb_a == w_msb_add) && (w_msb_r != w_msb_a);
        w_flags.n = w_msb_r;
        w_flags.z = bw ? (w_raw[BYTE_W-1:0] == '0) : (w_raw == '0);

        if (w_err) begin
            w_res   = '0;
            w_flags = '{v: 1'b0, n: 1'b0, z: 1'b1, c: 1'b0};
        end
    end

    // DADD digit chain: DADD_DIGITS digits per cycle, low digit first
    assign w_base = int'(r_cnt) * DADD_DIGITS * NIBBLE_W;
    assign w_dc[0] = r_dc;

    for (genvar k = 0; k < DADD_DIGITS; k++) begin : g_digit
        logic [NIBBLE_W-1:0] w_na, w_nb;
        assign w_na = r_da[w_base + k*NIBBLE_W +: NIBBLE_W];
        assign w_nb = r_db[w_base + k*NIBBLE_W +: NIBBLE_W];
        bcd_digit_add u_digit (
            .i_a    (w_na),
            .i_b    (w_nb),
            .i_cin  (w_dc[k]),
            .o_sum  (w_dsum[k*NIBBLE_W +: NIBBLE_W]),
            .o_cout (w_dc[k+1])
        );
    end

    always_comb begin
        w_acc_next = r_acc;
        for (int k = 0; k < DADD_DIGITS; k++) begin
            w_acc_next[w_base + k*NIBBLE_W +: NIBBLE_W] = w_dsum[k*NIBBLE_W +: NIBBLE_W];
        end
        w_dflags.v = 1'b0;
        w_dflags.c = w_dc[DADD_DIGITS];
        w_dflags.n = r_dbw ? w_acc_next[BYTE_W-1] : w_acc_next[WIDTH-1];
        w_dflags.z = r_dbw ? (w_acc_next[BYTE_W-1:0] == '0) : (w_acc_next == '0);
    end

    assign w_dadd_last = (r_state == ST_DADD_BUSY) && (r_cnt == (r_dbw ? LAST_BYTE : LAST_WORD));

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:      if (w_in_fire && (w_mode == ALU_DADD)) w_state_next = ST_DADD_BUSY;
            ST_DADD_BUSY: if (w_dadd_last) w_state_next = ST_IDLE;
            default:      w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_flags     <= '0;
            r_err       <= 1'b0;
            r_da        <= '0;
            r_db        <= '0;
            r_acc       <= '0;
            r_dc        <= 1'b0;
            r_dbw       <= 1'b0;
            r_cnt       <= '0;
        end else if (w_in_fire) begin
            if (w_mode == ALU_DADD) begin
                // Accumulator starts as a so byte mode keeps a's upper bits.
                r_da        <= a;
                r_db        <= b;
                r_acc       <= a;
                r_dc        <= carry_in;
                r_dbw       <= bw;
                r_cnt       <= '0;
                r_out_valid <= 1'b0;
            end else begin
                r_result    <= w_res;
                r_flags     <= w_flags;
                r_err       <= w_err;
                r_out_valid <= 1'b1;
            end
        end else if (r_state == ST_DADD_BUSY) begin
            r_acc <= w_acc_next;
            r_dc  <= w_dc[DADD_DIGITS];
            if (w_dadd_last) begin
                r_cnt       <= '0;
                r_result    <= w_acc_next;
                r_flags     <= w_dflags;
                r_err       <= 1'b0;
                r_out_valid <= 1'b1;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end else if (w_out_fire) begin
            r_out_valid <= 1'b0;
        end
    end

endmodule

`default_nettype wire
